// File: rtl/mux_arb_n.sv
// N-channel round-robin arbiter feeding a one-entry registered output stage.
// Optional manual grant override is compiled in when MUX_ARB_N_MANUAL_EN is defined.
module mux_arb_n #(
    parameter  int N  = 8,
    parameter  int W  = 1,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_sel
`ifdef MUX_ARB_N_MANUAL_EN
    ,
    input  logic           man_en,
    input  logic [SW-1:0]  man_sel
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_data;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] r_ptr;

    logic [W-1:0]  w_words [N];
    logic          w_load_en;
    logic          w_rr_vld;
    logic [SW-1:0] w_rr_grant;
    logic          w_grant_vld;
    logic [SW-1:0] w_grant;
    logic          w_ptr_upd;
    logic          w_xfer;

    for (genvar i = 0; i < N; i++) begin : g_words
        assign w_words[i] = in_data[i*W +: W];
    end

    // Round-robin search: first requester at or after ptr+1 (mod N) wins.
    always_comb begin : rr_search
        logic [SW-1:0] idx;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_rr_vld   = 1'b0;
        w_rr_grant = '0;
        idx        = '0;
        for (int k = 1; k <= N; k++) begin
            idx = SW'((int'(r_ptr) + k) % N);
            if (!w_rr_vld && in_valid[idx]) begin
                w_rr_vld   = 1'b1;
                w_rr_grant = idx;
            end
        end
    end

`ifdef MUX_ARB_N_MANUAL_EN
    assign w_grant_vld = man_en ? ((int'(man_sel) < N) && in_valid[man_sel]) : w_rr_vld;
    assign w_grant     = man_en ? man_sel : w_rr_grant;
    assign w_ptr_upd   = !man_en;
`else
    assign w_grant_vld = w_rr_vld;
    assign w_grant     = w_rr_grant;
    assign w_ptr_upd   = 1'b1;
`endif

    // Drain and refill in the same cycle is allowed; reset masks any handshake.
    assign w_load_en = (r_state == EMPTY) || out_ready;
    assign in_ready  = (!rst && w_load_en && w_grant_vld) ? (N'(1) << w_grant) : '0;
    assign w_xfer    = |in_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= SW'(N - 1);
        end else if (w_xfer) begin
            r_state <= FULL;
            r_data  <= w_words[w_grant];
            r_sel   <= w_grant;
            if (w_ptr_upd) begin
                r_ptr <= w_grant;
            end
        end else if (out_ready) begin
            r_state <= EMPTY;
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule

// File: doc/mux_arb_n.md
MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 SHALL have parameter N, default 8: number of input channels, legal range 2..16.
REQ-002 SHALL have parameter W, default 1: data width per channel, legal range 1..64.
REQ-003 SHALL derive localparam SW = clog2(N): select/grant index width.
REQ-004 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port in_data  input  N*W: channel i occupies bits [i*W+W-1 : i*W].
REQ-007 SHALL have port in_valid  input  N: channel i offers a word.
REQ-008 SHALL have port in_ready  output  N: channel i word accepted this cycle; combinational.
REQ-009 SHALL have port out_data  output  W: registered selected word.
REQ-010 SHALL have port out_valid  output  1: out_data/out_sel hold a word.
REQ-011 SHALL have port out_ready  input  1: downstream accepts the word.
REQ-012 SHALL have port out_sel  output  SW: source channel index of the word held in the output register.

Function
REQ-013 SHALL implement a one-entry output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 SHALL assert load_en = (EMPTY) or (FULL and out_ready), i.e. same-cycle drain and refill allowed.
REQ-015 SHALL pick grant by round-robin: search starts at ptr+1 modulo N, first channel with in_valid=1 wins.
REQ-016 SHALL assert in_ready[g] only for the granted channel g, only when load_en=1 and in_valid[g]=1; all other in_ready bits 0.
REQ-017 SHALL, on a transfer (in_valid[g] and in_ready[g]), load out_data<=word g, out_sel<=g, set FULL, and update ptr<=g.
REQ-018 SHALL leave ptr unchanged on cycles without a transfer.
REQ-019 SHALL go FULL->EMPTY when out_ready=1 and no input transfers in the same cycle.
REQ-020 SHALL hold out_data and out_sel stable while FULL and out_ready=0 (no overwrite, no loss).
REQ-021 SHALL have latency exactly 1 cycle: input accepted at edge k appears at out_data after edge k.
REQ-022 SHALL sustain one word per cycle when out_ready is held 1 and any in_valid is 1.
REQ-023 SHALL, with a single requester held continuously, grant it every load cycle (no starvation of a lone channel).
REQ-024 SHALL, with all channels requesting continuously, grant each channel exactly once per N transfers.
REQ-025 SHALL not depend combinationally from out_ready to out_data/out_valid.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, set out_valid=0, out_data=0, out_sel=0, ptr=N-1 (channel 0 highest priority first).
REQ-027 SHALL drive in_ready=0 during any cycle rst=1, discarding a word held mid-transfer.
REQ-028 SHALL let rst take precedence over any simultaneous transfer or drain.

Configuration
REQ-029 SHALL recognise macro MUX_ARB_N_MANUAL_EN.
REQ-030 SHALL, when MUX_ARB_N_MANUAL_EN is defined, add ports man_en input 1 and man_sel input SW.
REQ-031 SHALL, with man_en=1, grant only channel man_sel (no grant if man_sel>=N), and leave ptr unchanged.
REQ-032 SHALL, with man_en=0, or when the macro is undefined (ports absent), behave per REQ-015..REQ-024.

Verification
REQ-033 SHALL check: N=8,W=1, reset then in_valid=8'h01, in_data bit0=1, out_ready=1 -> in_ready=8'h01; next cycle out_valid=1, out_data=1, out_sel=0.
REQ-034 SHALL check: in_valid=8'hFF held, out_ready=1 for 16 cycles -> out_sel sequence 0,1,...,7,0,...,7.
REQ-035 SHALL check: FULL with out_sel=3, out_ready=0 for 5 cycles, in_valid=8'hFF -> in_ready=0, out_sel stays 3; on out_ready=1 next word is channel 4.
REQ-036 SHALL check: in_valid=8'h24 (channels 2,5), ptr=2 -> grant 5, then 2, alternating.
REQ-037 SHALL check: rst=1 asserted while FULL and in_valid=8'hFF -> next cycle out_valid=0, in_ready=0; after release, first grant is channel 0.
REQ-038 SHALL check (MUX_ARB_N_MANUAL_EN defined): man_en=1, man_sel=6, in_valid=8'hFF -> out_sel=6 every word; man_sel=6 with in_valid=8'hBF -> no transfer, out_valid falls to 0 after drain.
